// File: rtl/fetch_seq_if.sv
// Bundles the instruction-memory port, the decode hand-off and the EX redirect
// seen by fetch_seq. master = the sequencer, slave = memory/decode/EX side.
interface fetch_seq_if #(
    parameter int XLEN = 32
);
    // valid/ready: a request transfers on a cycle where imem_req_valid and
    // imem_req_ready are both high; likewise if_valid/if_ready to decode.
    // imem_rsp_valid and redirect_valid are single-cycle pulses with no ready.
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a time,
// buffers the returned word for decode and absorbs EX redirects at any phase.
module fetch_seq #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    output logic                busy,
    output logic [1:0]          dbg_state,
    fetch_seq_if.master         bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            drop, drop_nxt;
    logic            capture;
    logic            req_valid_q, if_valid_q, busy_q;
    logic [XLEN-1:0] if_instr_q, if_pc_q;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Redirect wins over every other transition in the same cycle.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.redirect_valid) pc_nxt = redirect_aligned;
                else if (fetch_en)      state_nxt = REQ;
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    pc_nxt = redirect_aligned;
                    if (bus.imem_req_ready) begin
                        state_nxt = WAIT;
                        drop_nxt  = 1'b1;
                    end
                end else if (bus.imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_nxt = redirect_aligned;
                    if (bus.imem_rsp_valid) begin
                        state_nxt = REQ;
                        drop_nxt  = 1'b0;
                    end else begin
                        drop_nxt  = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    if (drop) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_nxt    = redirect_aligned;
                    state_nxt = REQ;
                end else if (bus.if_ready) begin
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered off the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_VEC;
            drop        <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            drop        <= drop_nxt;
            req_valid_q <= (state_nxt == REQ);
            if_valid_q  <= (state_nxt == HOLD);
            busy_q      <= (state_nxt != IDLE);
            if (capture) begin
                if_instr_q <= bus.imem_rsp_data;
                if_pc_q    <= pc;
            end
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;
    assign busy               = busy_q;
    assign dbg_state          = state;
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: linear fetch, backpressure, redirects in every
// phase, misaligned redirect with PC wrap, and reset during an outstanding fetch.
module tb_fetch_seq;
    localparam logic [31:0] S_IDLE = 32'd0;
    localparam logic [31:0] S_REQ  = 32'd1;
    localparam logic [31:0] S_WAIT = 32'd2;
    localparam logic [31:0] S_HOLD = 32'd3;

    logic       clk;
    logic       rst_n;
    logic       fetch_en;
    logic       busy;
    logic [1:0] dbg_state;
    int         n_vec;
    int         n_bad;

    fetch_seq_if #(.XLEN(32)) bus ();

    fetch_seq #(.XLEN(32), .RESET_VEC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_en  (fetch_en),
        .busy      (busy),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] st, input logic rv,
                              input logic [31:0] addr, input logic iv);
        check({tag, ".state"}, 32'(dbg_state), st);
        check({tag, ".req_valid"}, 32'(bus.imem_req_valid), 32'(rv));
        check({tag, ".req_addr"}, bus.imem_req_addr, addr);
        check({tag, ".if_valid"}, 32'(bus.if_valid), 32'(iv));
    endtask

    // From REQ at address a: accept, answer next cycle with data, land in HOLD.
    task automatic fetch_one(input string tag, input logic [31:0] a, input logic [31:0] data);
        check_outs({tag, ".req"}, S_REQ, 1'b1, a, 1'b0);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check_outs({tag, ".wait"}, S_WAIT, 1'b0, a, 1'b0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        check_outs({tag, ".hold"}, S_HOLD, 1'b0, a, 1'b1);
        check({tag, ".if_pc"}, bus.if_pc, a);
        check({tag, ".if_instr"}, bus.if_instr, data);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        fetch_en = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        tick();
        tick();
        // reset state
        check_outs("rst", S_IDLE, 1'b0, 32'h0, 1'b0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.if_pc", bus.if_pc, 32'h0);
        check("rst.if_instr", bus.if_instr, 32'h0);

        // 1: linear fetch
        rst_n = 1'b1;
        fetch_en = 1'b1;
        check("t1.busy_first", 32'(busy), 32'd0);
        tick();
        check("t1.busy", 32'(busy), 32'd1);
        fetch_one("t1a", 32'h0, 32'h0000_0013);
        bus.if_ready = 1'b1;
        tick();
        bus.if_ready = 1'b0;
        fetch_one("t1b", 32'h4, 32'h0040_0093);
        bus.if_ready = 1'b1;
        tick();
        bus.if_ready = 1'b0;
        fetch_one("t1c", 32'h8, 32'h0080_0113);

        // 2: backpressure in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs("t2", S_HOLD, 1'b0, 32'h8, 1'b1);
            check("t2.if_instr", bus.if_instr, 32'h0080_0113);
            check("t2.if_pc", bus.if_pc, 32'h8);
        end
        bus.if_ready = 1'b1;
        tick();
        bus.if_ready = 1'b0;

        // 3: redirect while 0xC is outstanding, stale response dropped
        check_outs("t3.req", S_REQ, 1'b1, 32'hC, 1'b0);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        check_outs("t3.wait0", S_WAIT, 1'b0, 32'h100, 1'b0);
        tick();
        check_outs("t3.wait1", S_WAIT, 1'b0, 32'h100, 1'b0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        check_outs("t3.rereq", S_REQ, 1'b1, 32'h100, 1'b0);
        check("t3.if_instr", bus.if_instr, 32'h0080_0113);
        fetch_one("t3b", 32'h100, 32'h0330_0193);

        // 4a: redirect together with if_ready in HOLD
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        check_outs("t4a", S_REQ, 1'b1, 32'h200, 1'b0);
        // 4b: redirect together with response in WAIT
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0BAD_0BAD;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        check_outs("t4b", S_REQ, 1'b1, 32'h300, 1'b0);
        check("t4b.if_instr", bus.if_instr, 32'h0330_0193);

        // 5: misaligned redirect in unaccepted REQ, then wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        tick();
        bus.redirect_valid = 1'b0;
        fetch_one("t5", 32'hFFFF_FFFC, 32'h0050_0293);
        bus.if_ready = 1'b1;
        tick();
        bus.if_ready = 1'b0;
        fetch_one("t5w", 32'h0, 32'h0060_0313);
        bus.if_ready = 1'b1;
        tick();
        bus.if_ready = 1'b0;

        // 6: reset while the fetch of 0x4 is outstanding
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check_outs("t6.wait", S_WAIT, 1'b0, 32'h4, 1'b0);
        rst_n = 1'b0;
        fetch_en = 1'b0;
        #1;
        check_outs("t6.rst", S_IDLE, 1'b0, 32'h0, 1'b0);
        check("t6.busy", 32'(busy), 32'd0);
        check("t6.if_pc", bus.if_pc, 32'h0);
        check("t6.if_instr", bus.if_instr, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1234_5678;
        tick();
        rst_n = 1'b1;
        tick();
        bus.imem_rsp_valid = 1'b0;
        check_outs("t6.idle", S_IDLE, 1'b0, 32'h0, 1'b0);
        check("t6.if_instr_late", bus.if_instr, 32'h0);
        fetch_en = 1'b1;
        tick();
        fetch_one("t6r", 32'h0, 32'h0070_0393);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
